fetch_unit: RTL and testbench

- Instruction fetch stage; sits between the program-counter register and decode.
- Owns the sequential fetch address and issues word requests to instruction memory over a valid/ready handshake.
- Holds in-order responses in a DEPTH-slot buffer and presents {instr, pc} pairs to decode over a valid/ready handshake.
- Accepts redirects (branch/jump target) and flushes or discards all stale fetches.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC register and decode.
//
// Issues sequential word fetches to instruction memory, parks the in-order
// responses in a DEPTH-slot circular buffer and hands {instr, pc} pairs to
// decode. A redirect flushes the buffer, restarts fetch at the new target
// and silently discards every response still owed by memory for the old
// stream before any new request is issued.
//
// Ports:
//   clk_i             clock, all state updates on posedge
//   rst_ni            synchronous active-low reset
//   redirect_i        flush and restart fetch at redirect_pc_i
//   redirect_pc_i     redirect target (bits [1:0] ignored)
//   imem_req_valid_o  request valid
//   imem_req_ready_i  memory accepts request
//   imem_addr_o       word-aligned request address
//   imem_rsp_valid_i  in-order response valid (always accepted)
//   imem_rsp_data_i   instruction word
//   instr_valid_o     head slot holds a fetched instruction
//   instr_ready_i     decode consumes head
//   instr_o           head instruction
//   instr_pc_o        address of head instruction
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] slot_pc_q     [DEPTH];
  logic [31:0] slot_pc_d     [DEPTH];
  logic [31:0] slot_data_q   [DEPTH];
  logic [31:0] slot_data_d   [DEPTH];
  logic        slot_filled_q [DEPTH];
  logic        slot_filled_d [DEPTH];
  ptr_t        alloc_ptr_q, alloc_ptr_d;
  ptr_t        fill_ptr_q, fill_ptr_d;
  ptr_t        head_ptr_q, head_ptr_d;
  cnt_t        used_q, used_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_cnt_q, drop_cnt_d;

  logic req_fire;
  logic rsp_take;
  logic pop;

  // Requests stop while stale responses are still owed, so old and new
  // streams never interleave in the response path. Holding valid low under
  // reset keeps every output at zero (apart from the address) until release.
  assign imem_req_valid_o = rst_ni && !redirect_i && (used_q < cnt_t'(DEPTH))
                            && (drop_cnt_q == '0);
  assign imem_addr_o      = fetch_pc_q;

  assign instr_valid_o = (used_q != '0) && slot_filled_q[head_ptr_q];
  assign instr_o       = slot_data_q[head_ptr_q];
  assign instr_pc_o    = slot_pc_q[head_ptr_q];

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  // A response with nothing outstanding is spurious and ignored.
  assign rsp_take = imem_rsp_valid_i && (inflight_q != '0);
  assign pop      = instr_valid_o && instr_ready_i;

  // Allocation only happens when used < DEPTH, so alloc_ptr never equals the
  // head of a non-empty buffer; alloc, fill and pop always touch different
  // slots and can be applied in any order within one cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    slot_pc_d     = slot_pc_q;
    slot_data_d   = slot_data_q;
    slot_filled_d = slot_filled_q;
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    head_ptr_d    = head_ptr_q;
    used_d        = used_q;
    inflight_d    = inflight_q;
    drop_cnt_d    = drop_cnt_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      for (int i = 0; i < DEPTH; i++) begin
        slot_filled_d[i] = 1'b0;
      end
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      used_d      = '0;
      // Everything still outstanding belongs to the flushed stream; a
      // response landing this very cycle is already thrown away.
      inflight_d  = inflight_q - cnt_t'(rsp_take);
      drop_cnt_d  = inflight_q - cnt_t'(rsp_take);
    end else begin
      if (req_fire) begin
        slot_pc_d[alloc_ptr_q]     = fetch_pc_q;
        slot_filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d                = alloc_ptr_q + 1'b1;
        fetch_pc_d                 = fetch_pc_q + 32'd4;
      end
      if (rsp_take) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - 1'b1;
        end else begin
          slot_data_d[fill_ptr_q]   = imem_rsp_data_i;
          slot_filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d                = fill_ptr_q + 1'b1;
        end
      end
      if (pop) begin
        slot_filled_d[head_ptr_q] = 1'b0;
        head_ptr_d                = head_ptr_q + 1'b1;
      end
      inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
      used_d     = used_q + cnt_t'(req_fire) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]     <= '0;
        slot_data_q[i]   <= '0;
        slot_filled_q[i] <= 1'b0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      used_q      <= '0;
      inflight_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      slot_pc_q     <= slot_pc_d;
      slot_data_q   <= slot_data_d;
      slot_filled_q <= slot_filled_d;
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      head_ptr_q    <= head_ptr_d;
      used_q        <= used_d;
      inflight_q    <= inflight_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (DEPTH=2).
// Directed cycle-by-cycle vectors, hand-written redirect/reset sequences
// driven through a latency-programmable memory model, and a randomized
// phase checked against a stream-level reference model.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o)
  );

  typedef struct {
    logic        rst;
    logic        rqRdy;
    logic        rspV;
    logic [31:0] rspD;
    logic        inRdy;
    logic        expReqV;
    logic [31:0] expAddr;
    logic        expInV;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    int          chk;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } memEntry_t;

  vec_t      vecs[$];
  memEntry_t memQ[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int lat        = 1;
  bit randLat    = 1'b0;
  int staleCnt   = 0;
  int occ        = 0;
  int pops       = 0;
  logic [31:0] expReq = RESET_PC;
  logic [31:0] expPop = RESET_PC;

  logic        sReqValid, sInstrValid;
  logic [31:0] sAddr, sInstr, sPc;
  bit          popSeen;
  logic [31:0] popPc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic rst, input logic rqRdy, input logic rspV,
                                 input logic [31:0] rspD, input logic inRdy,
                                 input logic expReqV, input logic [31:0] expAddr,
                                 input logic expInV, input logic [31:0] expInstr,
                                 input logic [31:0] expPc, input int chk);
    vec_t v;
    v.rst = rst; v.rqRdy = rqRdy; v.rspV = rspV; v.rspD = rspD; v.inRdy = inRdy;
    v.expReqV = expReqV; v.expAddr = expAddr; v.expInV = expInV;
    v.expInstr = expInstr; v.expPc = expPc; v.chk = chk;
    vecs.push_back(v);
  endfunction

  // chk: 0 = no check, 1 = handshake/address only, 2 = also head instr/pc.
  function automatic void buildVectors();
    // Streaming with memory always ready and 1-cycle latency: two slots
    // sustain two fetches every three cycles (a freed slot is reusable
    // only on the cycle after the pop).
    addVec(0, 1, 0, 0,           1, 0, 0,  0, 0,           0,  0);
    addVec(0, 1, 0, 0,           1, 0, 0,  0, 0,           0,  2);
    addVec(1, 1, 0, 0,           1, 1, 0,  0, 0,           0,  1);
    addVec(1, 1, 1, memfn(0),    1, 1, 4,  0, 0,           0,  1);
    addVec(1, 1, 1, memfn(4),    1, 0, 8,  1, memfn(0),    0,  2);
    addVec(1, 1, 0, 0,           1, 1, 8,  1, memfn(4),    4,  2);
    addVec(1, 1, 1, memfn(8),    1, 1, 12, 0, 0,           0,  1);
    addVec(1, 1, 1, memfn(12),   1, 0, 16, 1, memfn(8),    8,  2);
    addVec(1, 1, 0, 0,           1, 1, 16, 1, memfn(12),   12, 2);
    // Decode stalled: two requests, then request valid drops; head holds.
    addVec(0, 1, 0, 0,           0, 0, 0,  0, 0,           0,  0);
    addVec(0, 1, 0, 0,           0, 0, 0,  0, 0,           0,  2);
    addVec(1, 1, 0, 0,           0, 1, 0,  0, 0,           0,  1);
    addVec(1, 1, 1, memfn(0),    0, 1, 4,  0, 0,           0,  1);
    addVec(1, 1, 1, memfn(4),    0, 0, 8,  1, memfn(0),    0,  2);
    addVec(1, 1, 0, 0,           0, 0, 8,  1, memfn(0),    0,  2);
    addVec(1, 1, 0, 0,           0, 0, 8,  1, memfn(0),    0,  2);
    addVec(1, 1, 0, 0,           1, 0, 8,  1, memfn(0),    0,  2);
    addVec(1, 1, 0, 0,           0, 1, 8,  1, memfn(4),    4,  2);
    addVec(1, 1, 1, memfn(8),    0, 0, 12, 1, memfn(4),    4,  2);
    addVec(1, 1, 0, 0,           1, 0, 12, 1, memfn(4),    4,  2);
    addVec(1, 1, 0, 0,           1, 1, 12, 1, memfn(8),    8,  2);
    // Memory not ready for 3 cycles: address held, fetch_pc frozen.
    addVec(0, 0, 0, 0,           1, 0, 0,  0, 0,           0,  0);
    addVec(0, 0, 0, 0,           1, 0, 0,  0, 0,           0,  2);
    addVec(1, 0, 0, 0,           1, 1, 0,  0, 0,           0,  1);
    addVec(1, 0, 0, 0,           1, 1, 0,  0, 0,           0,  1);
    addVec(1, 0, 0, 0,           1, 1, 0,  0, 0,           0,  1);
    addVec(1, 1, 0, 0,           1, 1, 0,  0, 0,           0,  1);
    addVec(1, 0, 1, memfn(0),    1, 1, 4,  0, 0,           0,  1);
    addVec(1, 0, 0, 0,           1, 1, 4,  1, memfn(0),    0,  2);
    addVec(1, 0, 0, 0,           1, 1, 4,  0, 0,           0,  1);
  endfunction

  task automatic applyVector(input vec_t v, input int idx);
    @(negedge clk_i);
    rst_ni           = v.rst;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = v.rqRdy;
    imem_rsp_valid_i = v.rspV;
    imem_rsp_data_i  = v.rspD;
    instr_ready_i    = v.inRdy;
    #1;
    if (v.chk >= 1) begin
      checkOutput($sformatf("vec%0d_req_valid", idx), 32'(imem_req_valid_o), 32'(v.expReqV));
      checkOutput($sformatf("vec%0d_addr", idx), imem_addr_o, v.expAddr);
      checkOutput($sformatf("vec%0d_instr_valid", idx), 32'(instr_valid_o), 32'(v.expInV));
    end
    if (v.chk == 2) begin
      checkOutput($sformatf("vec%0d_instr", idx), instr_o, v.expInstr);
      checkOutput($sformatf("vec%0d_pc", idx), instr_pc_o, v.expPc);
    end
    @(posedge clk_i);
    cyc++;
  endtask

  // One cycle with the memory model answering in order after 'lat' cycles.
  // Reference model: the accepted addresses and the popped pcs each form a
  // +4 stream restarted at every redirect/reset target; no request while
  // old-stream responses are owed; at most DEPTH fetched-but-unpopped words.
  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic rqRdy, input logic inRdy);
    logic rspV;
    @(negedge clk_i);
    rst_ni           = rst;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = rqRdy;
    instr_ready_i    = inRdy;
    rspV             = (memQ.size() > 0) && (memQ[0].due <= cyc);
    imem_rsp_valid_i = rspV;
    imem_rsp_data_i  = rspV ? memfn(memQ[0].addr) : $urandom;
    #1;
    sReqValid   = imem_req_valid_o;
    sAddr       = imem_addr_o;
    sInstrValid = instr_valid_o;
    sInstr      = instr_o;
    sPc         = instr_pc_o;

    if (!rst) begin
      memQ.delete();
      staleCnt = 0;
      occ      = 0;
      expReq   = RESET_PC;
      expPop   = RESET_PC;
    end else if (redir) begin
      checkOutput("redirect_req_valid", 32'(sReqValid), 32'd0);
      if (rspV) void'(memQ.pop_front());
      staleCnt = memQ.size();
      occ      = 0;
      expReq   = rpc & 32'hFFFF_FFFC;
      expPop   = rpc & 32'hFFFF_FFFC;
    end else begin
      if (sReqValid && rqRdy) begin
        checkOutput("req_addr", sAddr, expReq);
        checkOutput("req_while_stale", 32'(staleCnt), 32'd0);
        checkOutput("req_over_capacity", 32'(occ < DEPTH), 32'd1);
      end
      if (rspV) begin
        void'(memQ.pop_front());
        if (staleCnt > 0) staleCnt--;
      end
      if (sReqValid && rqRdy) begin
        memEntry_t e;
        e.due  = cyc + (randLat ? int'($urandom_range(1, 4)) : lat);
        e.addr = sAddr;
        memQ.push_back(e);
        expReq = expReq + 32'd4;
        occ++;
      end
      if (sInstrValid && inRdy) begin
        checkOutput("pop_pc", sPc, expPop);
        checkOutput("pop_instr", sInstr, memfn(expPop));
        popSeen = 1'b1;
        popPc   = sPc;
        expPop  = expPop + 32'd4;
        occ--;
        pops++;
      end
    end
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic waitForPop(input string name, input logic [31:0] expPc);
    int n = 0;
    popSeen = 1'b0;
    while (!popSeen && n < 30) begin
      applyStimulus(1, 0, '0, 1, 1);
      n++;
    end
    if (!popSeen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    else          checkOutput(name, popPc, expPc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int popsBefore;
    rst_ni           = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    instr_ready_i    = 1'b0;

    buildVectors();
    $display("[TB] applying %0d directed vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) applyVector(vecs[i], i);

    // Redirect with two requests outstanding (3-cycle memory).
    $display("[TB] redirect with stale fetches in flight");
    randLat = 1'b0;
    lat     = 3;
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    applyStimulus(1, 1, 32'h0000_0103, 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    checkOutput("seqA_drop1_req_valid", 32'(sReqValid), 32'd0);
    checkOutput("seqA_drop1_instr_valid", 32'(sInstrValid), 32'd0);
    applyStimulus(1, 0, '0, 1, 1);
    checkOutput("seqA_drop2_req_valid", 32'(sReqValid), 32'd0);
    applyStimulus(1, 0, '0, 1, 1);
    checkOutput("seqA_resume_req_valid", 32'(sReqValid), 32'd1);
    checkOutput("seqA_resume_addr", sAddr, 32'h0000_0100);
    waitForPop("seqA_first_pc", 32'h0000_0100);

    // Redirect coinciding with a pop and a response arrival.
    $display("[TB] redirect with simultaneous pop and response");
    lat = 1;
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    applyStimulus(1, 1, 32'h0000_0200, 1, 1);
    checkOutput("seqB_pop_in_redirect", 32'(sInstrValid), 32'd1);
    checkOutput("seqB_pop_pc", sPc, 32'h0);
    applyStimulus(1, 0, '0, 1, 1);
    checkOutput("seqB_req_valid_after", 32'(sReqValid), 32'd1);
    checkOutput("seqB_addr_after", sAddr, 32'h0000_0200);
    checkOutput("seqB_instr_valid_after", 32'(sInstrValid), 32'd0);
    waitForPop("seqB_first_pc", 32'h0000_0200);

    // Reset while both slots hold fetched instructions.
    $display("[TB] reset mid-stream");
    applyStimulus(0, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 1, 0);
    checkOutput("seqC_full_instr_valid", 32'(sInstrValid), 32'd1);
    checkOutput("seqC_full_req_valid", 32'(sReqValid), 32'd0);
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    checkOutput("seqC_instr_valid_after_rst", 32'(sInstrValid), 32'd0);
    checkOutput("seqC_addr_after_rst", sAddr, RESET_PC);
    checkOutput("seqC_req_valid_after_rst", 32'(sReqValid), 32'd1);
    waitForPop("seqC_first_pc", RESET_PC);

    // Randomized traffic against the stream-level model.
    $display("[TB] randomized phase");
    randLat    = 1'b1;
    popsBefore = pops;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 31) == 0),
                    $urandom,
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) < 3));
    end
    checkOutput("random_progress", 32'((pops - popsBefore) > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
